// File: rtl/pipelined_mul_param.sv
// Parameterised pipelined shift-add multiplier with a signed/unsigned mode per transaction,
// a valid/ready handshake that stalls the whole pipe, and a sideband tag carried alongside.

module pipelined_mul_stage #(
  parameter int W    = 32,
  parameter int K    = 4,
  parameter int LO   = 0,
  parameter bit LAST = 1'b0
) (
  input  logic         sgn,
  input  logic [W-1:0] a_ext,
  input  logic [K-1:0] b_bits,
  input  logic [W-1:0] acc_in,
  output logic [W-1:0] acc_out
);
  // The MSB of a two's complement multiplier carries weight -2^(M-1), so it subtracts.
  always_comb begin
    acc_out = acc_in;
    for (int j = 0; j < K; j++) begin
      if (b_bits[j]) begin
        if (LAST && (j == K - 1) && sgn) acc_out = acc_out - (a_ext << (LO + j));
        else                             acc_out = acc_out + (a_ext << (LO + j));
      end
    end
  end
endmodule

module pipelined_mul_param #(
  parameter int N      = 16,
  parameter int M      = 16,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [N-1:0]     multiplicand,
  input  logic [M-1:0]     multiplier,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N+M-1:0]   Product,
  output logic [TAG_W-1:0] out_tag
);
  localparam int W = N + M;
  localparam int K = (STAGES > 0) ? M / STAGES : 1;

  if (N < 2 || M < 2 || TAG_W < 1 || STAGES < 1 || STAGES > M || (M % STAGES) != 0) begin : g_bad_params
    $error("pipelined_mul_param: illegal N/M/STAGES/TAG_W combination");
  end

  // Slot 0 only captures operands; slots 1..STAGES each retire K multiplier bits.
  logic                               adv;
  logic [STAGES:0]                    vld_q, vld_d;
  logic [STAGES:0][TAG_W-1:0]         tag_q, tag_d;
  logic [STAGES-1:0]                  sgn_q, sgn_d;
  logic [STAGES-1:0][W-1:0]           a_q, a_d;
  logic [STAGES-1:0][M-1:0]           b_q, b_d;
  logic [STAGES:1][W-1:0]             acc_q, acc_d, acc_nx;

  assign adv       = !vld_q[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES];
  assign Product   = acc_q[STAGES];
  assign out_tag   = tag_q[STAGES];

  for (genvar i = 1; i <= STAGES; i++) begin : g_stage
    logic [W-1:0] acc_in;
    if (i == 1) begin : g_first
      assign acc_in = '0;
    end else begin : g_rest
      assign acc_in = acc_q[i-1];
    end
    pipelined_mul_stage #(.W(W), .K(K), .LO((i - 1) * K), .LAST(i == STAGES)) u_stage (
      .sgn    (sgn_q[i-1]),
      .a_ext  (a_q[i-1]),
      .b_bits (b_q[i-1][K-1:0]),
      .acc_in (acc_in),
      .acc_out(acc_nx[i])
    );
  end

  // Datapath slots load only behind a valid entry, so a bubble leaves Product untouched.
  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    sgn_d = sgn_q;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (adv) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        sgn_d[0] = in_signed;
        a_d[0]   = in_signed ? {{M{multiplicand[N-1]}}, multiplicand} : {{M{1'b0}}, multiplicand};
        b_d[0]   = multiplier;
        tag_d[0] = in_tag;
      end
      for (int i = 1; i <= STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) begin
          tag_d[i] = tag_q[i-1];
          acc_d[i] = acc_nx[i];
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (vld_q[i-1]) begin
          sgn_d[i] = sgn_q[i-1];
          a_d[i]   = a_q[i-1];
          b_d[i]   = b_q[i-1] >> K;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      tag_q <= '0;
      sgn_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      sgn_q <= sgn_d;
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: tb/tb_pipelined_mul_param.sv
// Bench for pipelined_mul_param: directed cases on the default build plus a random
// sweep over three geometries, all checked against a plain-arithmetic product model.
module tb_pipelined_mul_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default-configuration DUT
  logic        in_valid, in_signed, out_ready;
  logic [15:0] a, b;
  logic [3:0]  tag;
  logic        in_ready, out_valid;
  logic [31:0] prod;
  logic [3:0]  out_tag;

  pipelined_mul_param u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .multiplicand(a), .multiplier(b), .in_tag(tag), .out_valid(out_valid),
    .out_ready(out_ready), .Product(prod), .out_tag(out_tag)
  );

  // sweep DUTs
  localparam int SN[3] = '{8, 16, 16};
  localparam int SM[3] = '{12, 16, 16};
  localparam int SS[3] = '{3, 1, 16};
  localparam int SWEEP_N = 1000;

  logic        sw_iv[3], sw_sg[3], sw_or[3], sw_ir[3], sw_ov[3];
  logic [15:0] sw_a[3], sw_b[3];
  logic [3:0]  sw_tag[3], sw_ot[3];
  logic [19:0] p0;
  logic [31:0] p1, p2;

  pipelined_mul_param #(.N(8), .M(12), .STAGES(3), .TAG_W(4)) u_sw0 (
    .clk(clk), .rst(rst), .in_valid(sw_iv[0]), .in_ready(sw_ir[0]), .in_signed(sw_sg[0]),
    .multiplicand(sw_a[0][7:0]), .multiplier(sw_b[0][11:0]), .in_tag(sw_tag[0]),
    .out_valid(sw_ov[0]), .out_ready(sw_or[0]), .Product(p0), .out_tag(sw_ot[0]));
  pipelined_mul_param #(.N(16), .M(16), .STAGES(1), .TAG_W(4)) u_sw1 (
    .clk(clk), .rst(rst), .in_valid(sw_iv[1]), .in_ready(sw_ir[1]), .in_signed(sw_sg[1]),
    .multiplicand(sw_a[1]), .multiplier(sw_b[1]), .in_tag(sw_tag[1]),
    .out_valid(sw_ov[1]), .out_ready(sw_or[1]), .Product(p1), .out_tag(sw_ot[1]));
  pipelined_mul_param #(.N(16), .M(16), .STAGES(16), .TAG_W(4)) u_sw2 (
    .clk(clk), .rst(rst), .in_valid(sw_iv[2]), .in_ready(sw_ir[2]), .in_signed(sw_sg[2]),
    .multiplicand(sw_a[2]), .multiplier(sw_b[2]), .in_tag(sw_tag[2]),
    .out_valid(sw_ov[2]), .out_ready(sw_or[2]), .Product(p2), .out_tag(sw_ot[2]));

  typedef struct {
    logic [31:0] p;
    logic [3:0]  t;
    int          e;
    int          s;
  } exp_t;
  exp_t sq[3][$];

  // exact product of n-bit x and m-bit y, reduced to n+m bits
  function automatic logic [63:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                          input int n, input int m, input bit sg);
    longint xv, yv, pr;
    xv = longint'(x) & ((longint'(1) << n) - 1);
    yv = longint'(y) & ((longint'(1) << m) - 1);
    if (sg && x[n-1]) xv = xv - (longint'(1) << n);
    if (sg && y[m-1]) yv = yv - (longint'(1) << m);
    pr = xv * yv;
    return 64'(pr) & ((64'd1 << (n + m)) - 1);
  endfunction

  function automatic logic [15:0] pick(input int w);
    logic [15:0] msk;
    msk = 16'((32'd1 << w) - 1);
    case ($urandom_range(0, 7))
      0:       return 16'd0;
      1:       return msk;
      2:       return 16'(32'd1 << (w - 1));
      3:       return 16'((32'd1 << (w - 1)) - 1);
      default: return 16'($urandom()) & msk;
    endcase
  endfunction

  function automatic logic [31:0] sw_p(input int c);
    case (c)
      0:       return {12'd0, p0};
      1:       return p1;
      default: return p2;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_signed = 1'b0; out_ready = 1'b1; a = '0; b = '0; tag = '0;
    for (int c = 0; c < 3; c++) begin
      sw_iv[c] = 1'b0; sw_sg[c] = 1'b0; sw_or[c] = 1'b1;
      sw_a[c] = '0; sw_b[c] = '0; sw_tag[c] = '0;
    end
    #12;
    checks++;
    if (out_valid !== 1'b0 || prod !== 32'd0 || out_tag !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b Product=%h out_tag=%h, want 0/0/0", out_valid, prod, out_tag);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_unsigned_max();
    in_valid = 1'b1; in_signed = 1'b0; a = 16'hFFFF; b = 16'hFFFF; tag = 4'd3; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (out_valid !== (k == 4)) begin
        errors++;
        $display("FAIL umax_valid k=%0d: got %b want %b", k, out_valid, (k == 4));
      end
      if (k == 4) begin
        checks++;
        if (prod !== 32'hFFFE0001 || out_tag !== 4'd3) begin
          errors++;
          $display("FAIL umax_product: got %h tag %h want fffe0001 tag 3", prod, out_tag);
        end
      end
    end
  endtask

  task automatic test_signed_corners();
    logic [15:0] xa[4] = '{16'hFFFF, 16'h8000, 16'h8000, 16'h7FFF};
    logic [15:0] xb[4] = '{16'hFFFF, 16'h8000, 16'h0001, 16'h8000};
    logic [31:0] xp[4] = '{32'h00000001, 32'h40000000, 32'hFFFF8000, 32'hC0008000};
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k < 4) begin
        in_valid = 1'b1; in_signed = 1'b1; a = xa[k]; b = xb[k]; tag = 4'(k + 8);
      end else in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== (k >= 4 && k < 8)) begin
        errors++;
        $display("FAIL signed_valid k=%0d: got %b", k, out_valid);
      end
      if (k >= 4 && k < 8) begin
        checks++;
        if (prod !== xp[k-4] || out_tag !== 4'(k + 4)) begin
          errors++;
          $display("FAIL signed_corner %0d: got %h tag %h want %h tag %h", k - 4, prod, out_tag, xp[k-4], 4'(k + 4));
        end
      end
    end
  endtask

  task automatic test_mixed_mode();
    logic [31:0] xp[2] = '{32'h0001FFFE, 32'hFFFFFFFE};
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k < 2) begin
        in_valid = 1'b1; in_signed = (k == 1); a = 16'hFFFF; b = 16'h0002; tag = 4'(5 + k);
      end else in_valid = 1'b0;
      tick();
      if (k >= 4 && k < 6) begin
        checks++;
        if (out_valid !== 1'b1 || prod !== xp[k-4] || out_tag !== 4'(1 + k)) begin
          errors++;
          $display("FAIL mixed_mode %0d: valid %b got %h tag %h want %h", k - 4, out_valid, prod, out_tag, xp[k-4]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] mq[$];
    logic [3:0]  tq[$];
    logic [63:0] r;
    logic [31:0] ep;
    logic [3:0]  et;
    int sent = 0, rcvd = 0, cyc = 0;
    bit acc, xfer;
    in_valid = 1'b1; in_signed = 1'($urandom()); a = 16'($urandom()); b = 16'($urandom()); tag = 4'(sent);
    while (rcvd < 8 && cyc < 80) begin
      out_ready = !(cyc >= 5 && cyc <= 9);
      #1;
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++;
        $display("FAIL bp_in_ready cyc=%0d: got %b out_valid %b out_ready %b", cyc, in_ready, out_valid, out_ready);
      end
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        checks++;
        if (mq.size() == 0) begin
          errors++;
          $display("FAIL bp_extra_result: got %h with nothing outstanding", prod);
        end else begin
          ep = mq.pop_front(); et = tq.pop_front();
          if (prod !== ep || out_tag !== et) begin
            errors++;
            $display("FAIL bp_result %0d: got %h tag %h want %h tag %h", rcvd, prod, out_tag, ep, et);
          end
        end
        rcvd++;
      end
      if (acc) begin
        r = ref_mul(a, b, 16, 16, in_signed);
        mq.push_back(r[31:0]); tq.push_back(tag);
        sent++;
      end
      tick();
      cyc++;
      if (acc) begin
        if (sent < 8) begin
          in_signed = 1'($urandom()); a = 16'($urandom()); b = 16'($urandom()); tag = 4'(sent);
        end else in_valid = 1'b0;
      end
    end
    checks++;
    if (rcvd != 8 || mq.size() != 0) begin
      errors++;
      $display("FAIL bp_count: received %0d outstanding %0d want 8 and 0", rcvd, mq.size());
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_duplicate: out_valid %b after drain want 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    logic [63:0] r;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_signed = 1'b0; a = 16'($urandom()) | 16'h1; b = 16'($urandom()) | 16'h1; tag = 4'hA;
      tick();
    end
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || prod !== 32'd0 || out_tag !== 4'd0) begin
      errors++;
      $display("FAIL midflight_reset: out_valid %b Product %h out_tag %h want 0/0/0", out_valid, prod, out_tag);
    end
    #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midflight_stale k=%0d: out_valid %b want 0", k, out_valid);
      end
    end
    in_valid = 1'b1; in_signed = 1'b1; a = 16'($urandom()); b = 16'($urandom()); tag = 4'h6;
    r = ref_mul(a, b, 16, 16, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (out_valid !== (k == 4)) begin
        errors++;
        $display("FAIL midflight_latency k=%0d: out_valid %b", k, out_valid);
      end
      if (k == 4) begin
        checks++;
        if (prod !== r[31:0] || out_tag !== 4'h6) begin
          errors++;
          $display("FAIL midflight_next: got %h tag %h want %h tag 6", prod, out_tag, r[31:0]);
        end
      end
    end
  endtask

  task automatic sw_new_op(input int c);
    sw_iv[c]  = 1'b1;
    sw_sg[c]  = 1'($urandom());
    sw_a[c]   = pick(SN[c]);
    sw_b[c]   = pick(SM[c]);
    sw_tag[c] = 4'($urandom());
  endtask

  task automatic test_sweep();
    int issued[3], got[3], stalls[3];
    bit pre_adv[3], acc[3];
    int edge_n = 0, cyc = 0;
    bit done;
    exp_t x;
    logic [63:0] r;
    for (int c = 0; c < 3; c++) begin
      issued[c] = 0; got[c] = 0; stalls[c] = 0;
      sw_new_op(c);
    end
    done = 1'b0;
    while (!done && cyc < 20000) begin
      for (int c = 0; c < 3; c++) sw_or[c] = ($urandom_range(0, 3) != 0);
      #1;
      for (int c = 0; c < 3; c++) begin
        pre_adv[c] = sw_ir[c];
        checks++;
        if (sw_ir[c] !== (!sw_ov[c] || sw_or[c])) begin
          errors++;
          $display("FAIL sweep%0d_in_ready: got %b", c, sw_ir[c]);
        end
        if (!sw_ir[c]) stalls[c]++;
        acc[c] = sw_iv[c] && sw_ir[c];
        if (acc[c]) begin
          r = ref_mul(sw_a[c], sw_b[c], SN[c], SM[c], sw_sg[c]);
          x.p = r[31:0]; x.t = sw_tag[c]; x.e = edge_n + 1; x.s = stalls[c];
          sq[c].push_back(x);
          issued[c]++;
        end
      end
      @(posedge clk);
      edge_n++;
      cyc++;
      #1;
      for (int c = 0; c < 3; c++) begin
        if (sw_ov[c] && pre_adv[c]) begin
          checks++;
          if (sq[c].size() == 0) begin
            errors++;
            $display("FAIL sweep%0d_spurious: got %h", c, sw_p(c));
          end else begin
            x = sq[c].pop_front();
            if (sw_p(c) !== x.p || sw_ot[c] !== x.t || (edge_n - x.e) != SS[c] + (stalls[c] - x.s)) begin
              errors++;
              $display("FAIL sweep%0d_result %0d: got %h tag %h lat %0d want %h tag %h lat %0d", c, got[c],
                       sw_p(c), sw_ot[c], edge_n - x.e, x.p, x.t, SS[c] + (stalls[c] - x.s));
            end
          end
          got[c]++;
        end
        if (acc[c]) begin
          if (issued[c] < SWEEP_N) sw_new_op(c);
          else sw_iv[c] = 1'b0;
        end
      end
      done = (got[0] >= SWEEP_N) && (got[1] >= SWEEP_N) && (got[2] >= SWEEP_N);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (got[c] != SWEEP_N || sq[c].size() != 0) begin
        errors++;
        $display("FAIL sweep%0d_count: got %0d outstanding %0d want %0d and 0", c, got[c], sq[c].size(), SWEEP_N);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_corners();
    test_mixed_mode();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
